// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the cache-to-RAM arbiter.
//   word_t      : 32-bit memory word.
//   ramstate_t  : RAM handshake state reported by the RAM model/controller.
//   arb_state_t : arbiter grant state.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// arb_starve_ctr
//   Saturating counter tracking consecutive dcache grants made while the
//   icache is waiting.
//   CLK  : clock
//   nRST : asynchronous active-low reset
//   inc  : count one dcache grant (ignored once saturated)
//   clr  : return to zero (wins over inc)
//   sat  : counter has reached MAX
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [3:0] cnt_r;

  // Count state: clear has priority, increment stops at MAX.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (inc && (cnt_r != 4'(MAX))) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == 4'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates icache and dcache word requests onto a single-ported RAM.
//   Dcache has priority; a two-word dcache block (addr bit 2 = 0 then 1) is
//   held locked so it is never split. After STARVE_MAX consecutive dcache
//   grants with the icache waiting, the icache is forced a grant.
//   Ports:
//     CLK, nRST               : clock, async active-low reset
//     iREN, iaddr             : icache read request/address
//     iwait, iload            : icache stall (low on completion) / read data
//     dREN, dWEN, daddr,
//     dstore                  : dcache read/write request, address, write data
//     dwait, dload            : dcache stall (low on completion) / read data
//     ramREN, ramWEN, ramaddr,
//     ramstore                : RAM strobes, address, write data
//     ramload, ramstate       : RAM read data and handshake state
//     memerr                  : sticky, RAM reported ERROR during a grant
//     icnt, dcnt              : completed icache / dcache words (wrapping)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  output logic             iwait,
  output logic [31:0]      iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic             dwait,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic             memerr,
  output logic [CNT_W-1:0] icnt,
  output logic [CNT_W-1:0] dcnt
);

  arb_state_t       state_r;
  arb_state_t       next_s;
  ramstate_t        rs_s;
  logic             memerr_r;
  logic [CNT_W-1:0] icnt_r;
  logic [CNT_W-1:0] dcnt_r;
  logic             dreq_s;
  logic             drd_s;
  logic             i_done_s;
  logic             d_done_s;
  logic             err_s;
  logic             starve_inc_s;
  logic             starve_clr_s;
  logic             starve_sat_s;

  assign rs_s   = ramstate_t'(ramstate);
  assign dreq_s = dREN | dWEN;
  // A write wins when both dcache strobes are up.
  assign drd_s  = dREN & ~dWEN;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (starve_inc_s),
    .clr  (starve_clr_s),
    .sat  (starve_sat_s)
  );

  // Grant decode: RAM strobes, wait/load, completion events, next state.
  always_comb begin
    next_s       = state_r;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'd0;
    ramstore     = 32'd0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = 32'd0;
    dload        = 32'd0;
    i_done_s     = 1'b0;
    d_done_s     = 1'b0;
    err_s        = 1'b0;
    starve_inc_s = 1'b0;
    starve_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!iREN) begin
          starve_clr_s = 1'b1;
        end else begin
          starve_clr_s = 1'b0;
        end
        // Forced icache grant only ever happens here, so a locked block
        // in DGNT can never be interrupted by it.
        if (dreq_s && !(starve_sat_s && iREN)) begin
          next_s = DGNT;
        end else if (iREN) begin
          next_s = IGNT;
        end else begin
          next_s = IDLE;
        end
      end
      DGNT: begin
        if (dreq_s) begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = drd_s;
          case (rs_s)
            ACCESS: begin
              dwait    = 1'b0;
              dload    = drd_s ? ramload : 32'd0;
              d_done_s = 1'b1;
              // First word of a block keeps the lock and does not count
              // toward starvation; the second word (or a single) does.
              if (daddr[2]) begin
                starve_inc_s = iREN;
                next_s       = IDLE;
              end else begin
                starve_inc_s = 1'b0;
                next_s       = DGNT;
              end
            end
            ERROR: begin
              err_s = 1'b1;
            end
            default: begin
              err_s = 1'b0;
            end
          endcase
        end else begin
          // Dcache withdrew: release the lock without strobing.
          next_s = IDLE;
        end
      end
      IGNT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          case (rs_s)
            ACCESS: begin
              iwait        = 1'b0;
              iload        = ramload;
              i_done_s     = 1'b1;
              starve_clr_s = 1'b1;
              // Hand straight to a waiting dcache with no idle bubble.
              next_s       = dreq_s ? DGNT : IDLE;
            end
            ERROR: begin
              err_s = 1'b1;
            end
            default: begin
              err_s = 1'b0;
            end
          endcase
        end else begin
          next_s = IDLE;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Grant state, sticky error flag and completion counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      memerr_r <= 1'b0;
      icnt_r   <= {CNT_W{1'b0}};
      dcnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_s;
      if (err_s) begin
        memerr_r <= 1'b1;
      end
      if (i_done_s) begin
        icnt_r <= icnt_r + CNT_W'(1);
      end
      if (d_done_s) begin
        dcnt_r <= dcnt_r + CNT_W'(1);
      end
    end
  end

  assign memerr = memerr_r;
  assign icnt   = icnt_r;
  assign dcnt   = dcnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;
  logic [31:0] icnt;
  logic [31:0] dcnt;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.STARVE_MAX(4), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .memerr(memerr), .icnt(icnt), .dcnt(dcnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = 2'd0;
    #2;
    chk1("rst_iwait", iwait, 1'b1);
    chk1("rst_dwait", dwait, 1'b1);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk1("rst_memerr", memerr, 1'b0);
    chk("rst_icnt", icnt, 32'd0);
    chk("rst_dcnt", dcnt, 32'd0);
    tick(); tick();
    nRST = 1'b1;

    // Icache only, two BUSY cycles then ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1;
    #1 chk1("t1_arb_no_strobe", ramREN, 1'b0);
    tick();
    #1 chk1("t1_ramREN", ramREN, 1'b1);
    chk("t1_ramaddr", ramaddr, 32'h40);
    tick();
    #1 chk1("t1_busy_iwait", iwait, 1'b1);
    tick();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #1 chk1("t1_iwait", iwait, 1'b0);
    chk("t1_iload", iload, 32'hDEADBEEF);
    chk1("t1_dwait", dwait, 1'b1);
    chk("t1_dload", dload, 32'd0);
    tick();

    // Dcache block write-back with iREN held
    ramstate = 2'd1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h11;
    #1 chk("t1_icnt", icnt, 32'd1);
    chk1("t2_arb_no_strobe", ramWEN, 1'b0);
    tick();
    ramstate = 2'd2;
    #1 chk1("t2_w0_ramWEN", ramWEN, 1'b1);
    chk1("t2_w0_ramREN", ramREN, 1'b0);
    chk("t2_w0_ramaddr", ramaddr, 32'h100);
    chk("t2_w0_ramstore", ramstore, 32'h11);
    chk1("t2_w0_dwait", dwait, 1'b0);
    chk1("t2_w0_iwait", iwait, 1'b1);
    tick();
    daddr = 32'h104; dstore = 32'h22;
    #1 chk1("t2_w1_ramWEN", ramWEN, 1'b1);
    chk("t2_w1_ramaddr", ramaddr, 32'h104);
    chk("t2_w1_ramstore", ramstore, 32'h22);
    chk1("t2_w1_iwait", iwait, 1'b1);
    tick();
    dWEN = 1'b0; ramstate = 2'd1;
    #1 chk("t2_dcnt", dcnt, 32'd2);
    chk1("t2_idle_ramWEN", ramWEN, 1'b0);
    tick();
    ramstate = 2'd2; ramload = 32'h5;
    #1 chk1("t2_igrant_ramREN", ramREN, 1'b1);
    chk("t2_igrant_ramaddr", ramaddr, 32'h40);
    chk("t2_iload", iload, 32'h5);
    tick();

    // Simultaneous requests: four dcache singles, fifth decision to icache
    dREN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      daddr = 32'h104 + 32'(k) * 32'd8; ramstate = 2'd0;
      #1 chk1("t3_arb_no_strobe", ramREN, 1'b0);
      tick();
      ramstate = 2'd2; ramload = 32'hA0 + 32'(k);
      #1 chk("t3_d_ramaddr", ramaddr, 32'h104 + 32'(k) * 32'd8);
      chk("t3_dload", dload, 32'hA0 + 32'(k));
      chk1("t3_iwait", iwait, 1'b1);
      tick();
    end
    ramstate = 2'd0;
    #1 chk1("t3_arb5_no_strobe", ramREN, 1'b0);
    tick();
    ramstate = 2'd2; ramload = 32'h77;
    #1 chk("t3_forced_ramaddr", ramaddr, 32'h40);
    chk("t3_forced_iload", iload, 32'h77);
    chk1("t3_forced_dwait", dwait, 1'b1);
    chk("t3_forced_dload", dload, 32'd0);
    tick();
    // Handoff straight to dcache, no bubble
    daddr = 32'h124; ramload = 32'h88;
    #1 chk1("t3_handoff_ramREN", ramREN, 1'b1);
    chk("t3_handoff_ramaddr", ramaddr, 32'h124);
    chk("t3_handoff_dload", dload, 32'h88);
    tick();

    // Two more singles bring starve to 3, then a locked block
    for (int k = 0; k < 2; k++) begin
      daddr = 32'h12C + 32'(k) * 32'd8; ramstate = 2'd0;
      #1 chk1("t4_arb_no_strobe", ramREN, 1'b0);
      tick();
      ramstate = 2'd2; ramload = 32'h90 + 32'(k);
      #1 chk("t4_dload", dload, 32'h90 + 32'(k));
      tick();
    end
    daddr = 32'h200; ramstate = 2'd0;
    #1 chk1("t4_blk_arb", ramREN, 1'b0);
    tick();
    ramstate = 2'd2; ramload = 32'hB0;
    #1 chk("t4_blk0_ramaddr", ramaddr, 32'h200);
    chk("t4_blk0_dload", dload, 32'hB0);
    tick();
    daddr = 32'h204; ramstate = 2'd1;
    #1 chk("t4_blk1_ramaddr", ramaddr, 32'h204);
    chk1("t4_blk1_iwait", iwait, 1'b1);
    chk1("t4_blk1_busy_dwait", dwait, 1'b1);
    tick();
    ramstate = 2'd2; ramload = 32'hB1;
    #1 chk("t4_blk1_dload", dload, 32'hB1);
    tick();
    ramstate = 2'd0;
    #1 chk1("t4_post_blk_arb", ramREN, 1'b0);
    tick();
    ramstate = 2'd2; ramload = 32'hC0;
    #1 chk("t4_forced_ramaddr", ramaddr, 32'h40);
    chk("t4_forced_iload", iload, 32'hC0);
    chk1("t4_forced_dwait", dwait, 1'b1);
    tick();
    // In DGNT after handoff, dcache withdraws: no strobes
    dREN = 1'b0; iREN = 1'b0; ramstate = 2'd0;
    #1 chk1("t4_drop_ramREN", ramREN, 1'b0);
    chk("t4_drop_ramaddr", ramaddr, 32'd0);
    tick();

    // dREN+dWEN together, ERROR then ACCESS
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h33; ramstate = 2'd1;
    #1 chk1("t5_arb_ramWEN", ramWEN, 1'b0);
    tick();
    #1 chk1("t5_ramWEN", ramWEN, 1'b1);
    chk1("t5_ramREN", ramREN, 1'b0);
    chk("t5_ramstore", ramstore, 32'h33);
    chk1("t5_busy_dwait", dwait, 1'b1);
    chk1("t5_memerr0", memerr, 1'b0);
    tick();
    ramstate = 2'd3;
    #1 chk1("t6_err_dwait", dwait, 1'b1);
    chk1("t6_err_ramWEN", ramWEN, 1'b1);
    tick();
    ramstate = 2'd2; ramload = 32'hFF;
    #1 chk1("t6_dwait", dwait, 1'b0);
    chk("t6_write_dload", dload, 32'd0);
    chk1("t6_memerr", memerr, 1'b1);
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
    #1 chk1("t6_release_ramWEN", ramWEN, 1'b0);
    chk1("t6_memerr_sticky", memerr, 1'b1);
    tick();
    #1 chk("t6_dcnt", dcnt, 32'd12);
    chk("t6_icnt", icnt, 32'd4);
    chk1("t6_memerr_idle", memerr, 1'b1);

    // Reset in the middle of a dcache grant
    dREN = 1'b1; daddr = 32'h404; ramstate = 2'd1;
    tick();
    #1 chk1("t7_pre_ramREN", ramREN, 1'b1);
    #1 nRST = 1'b0;
    #1 chk1("t7_rst_ramREN", ramREN, 1'b0);
    chk("t7_rst_ramaddr", ramaddr, 32'd0);
    chk1("t7_rst_dwait", dwait, 1'b1);
    chk1("t7_rst_memerr", memerr, 1'b0);
    chk("t7_rst_dcnt", dcnt, 32'd0);
    chk("t7_rst_icnt", icnt, 32'd0);
    tick();
    nRST = 1'b1;
    #1 chk1("t7_rearb_ramREN", ramREN, 1'b0);
    tick();
    ramstate = 2'd2; ramload = 32'h99;
    #1 chk1("t7_ramREN", ramREN, 1'b1);
    chk("t7_ramaddr", ramaddr, 32'h404);
    chk("t7_dload", dload, 32'h99);
    tick();
    dREN = 1'b0; ramstate = 2'd0;
    #1 chk("t7_dcnt", dcnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
